// File: rtl/free_ptr_manager.sv
// Free-address pool for the shared cell buffer: self-initialising circular list of free pointers.
// Define FREE_PTR_DFREE_CHK_EN to add an allocated-pointer bitmap that rejects double frees.
module free_ptr_manager #(
    parameter int DEPTH  = 256,
    parameter int LOW_WM = 8,
    parameter int PW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alloc_req,
    output logic          alloc_valid,
    output logic [PW-1:0] alloc_ptr,
    input  logic          release_en,
    input  logic [PW-1:0] release_ptr,
    input  logic          err_clr,
    output logic [PW:0]   free_count,
    output logic          empty,
    output logic          full,
    output logic          low_wm,
    output logic          init_done,
    output logic          release_err
);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]   LOW_CNT  = (PW+1)'(LOW_WM);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

    typedef enum logic {S_INIT, S_READY} state_e;

    state_e        state_q;
    logic [PW-1:0] init_cnt_q;
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [PW:0]   free_cnt_q, free_cnt_d;
    logic          empty_q, full_q, init_done_q;
    logic          release_err_q, release_err_d;
    logic [PW-1:0] ram_q [DEPTH];

    logic alloc_fire, rel_ok, rel_drop, dfree_ok;

`ifdef FREE_PTR_DFREE_CHK_EN
    logic [DEPTH-1:0] alloc_map_q;
    // Pre-update bitmap: a same-cycle alloc of the same pointer does not validate the release.
    assign dfree_ok = alloc_map_q[release_ptr];
`else
    assign dfree_ok = 1'b1;
`endif

    assign alloc_valid = (state_q == S_READY) && !empty_q;
    assign alloc_ptr   = ram_q[rd_ptr_q];
    assign alloc_fire  = alloc_req && alloc_valid;
    assign rel_ok      = release_en && (state_q == S_READY) && !full_q && dfree_ok;
    assign rel_drop    = release_en && !rel_ok;

    assign free_count  = free_cnt_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign low_wm      = (free_cnt_q <= LOW_CNT);
    assign init_done   = init_done_q;
    assign release_err = release_err_q;

    always_comb begin
        free_cnt_d = free_cnt_q;
        case ({alloc_fire, rel_ok})
            2'b10:   free_cnt_d = free_cnt_q - 1'b1;
            2'b01:   free_cnt_d = free_cnt_q + 1'b1;
            default: free_cnt_d = free_cnt_q;
        endcase
        release_err_d = release_err_q;
        if (rel_drop)     release_err_d = 1'b1;
        else if (err_clr) release_err_d = 1'b0;
    end

    // Pointer storage carries no reset; INIT rewrites every entry.
    always_ff @(posedge clk) begin
        if (state_q == S_INIT)
            ram_q[init_cnt_q] <= init_cnt_q;
        else if (rel_ok)
            ram_q[wr_ptr_q] <= release_ptr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_INIT;
            init_cnt_q    <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            free_cnt_q    <= '0;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
            init_done_q   <= 1'b0;
            release_err_q <= 1'b0;
`ifdef FREE_PTR_DFREE_CHK_EN
            alloc_map_q   <= '0;
`endif
        end else begin
            release_err_q <= release_err_d;
            case (state_q)
                S_INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == LAST_IDX) begin
                        state_q     <= S_READY;
                        rd_ptr_q    <= '0;
                        wr_ptr_q    <= '0;
                        free_cnt_q  <= FULL_CNT;
                        empty_q     <= 1'b0;
                        full_q      <= 1'b1;
                        init_done_q <= 1'b1;
                    end
                end
                default: begin
                    if (alloc_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
                    if (rel_ok)     wr_ptr_q <= wr_ptr_q + 1'b1;
                    free_cnt_q <= free_cnt_d;
                    empty_q    <= (free_cnt_d == '0);
                    full_q     <= (free_cnt_d == FULL_CNT);
`ifdef FREE_PTR_DFREE_CHK_EN
                    if (rel_ok)     alloc_map_q[release_ptr] <= 1'b0;
                    if (alloc_fire) alloc_map_q[alloc_ptr]   <= 1'b1;
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_free_ptr_manager.sv
// Directed bench for free_ptr_manager (DEPTH=8, LOW_WM=4); inputs driven and outputs checked on negedge.
module tb_free_ptr_manager;
    localparam int DEPTH = 8;
    localparam int PW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alloc_req, release_en, err_clr;
    logic [PW-1:0] release_ptr;
    logic          alloc_valid, empty, full, low_wm, init_done, release_err;
    logic [PW-1:0] alloc_ptr;
    logic [PW:0]   free_count;

    int errors = 0;
    int checks = 0;

    free_ptr_manager #(.DEPTH(DEPTH), .LOW_WM(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_valid(alloc_valid), .alloc_ptr(alloc_ptr),
        .release_en(release_en), .release_ptr(release_ptr), .err_clr(err_clr),
        .free_count(free_count), .empty(empty), .full(full), .low_wm(low_wm),
        .init_done(init_done), .release_err(release_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        int q[$];
        int head;
        rst_n = 1'b0; alloc_req = 1'b0; release_en = 1'b0; err_clr = 1'b0; release_ptr = '0;
        repeat (2) cyc();

        // reset values
        chk("rst_alloc_valid", alloc_valid, 0);
        chk("rst_free_count", free_count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_low_wm", low_wm, 1);
        chk("rst_init_done", init_done, 0);
        chk("rst_release_err", release_err, 0);

        // init takes exactly DEPTH edges
        rst_n = 1'b1;
        repeat (DEPTH - 1) cyc();
        chk("init_done_edge7", init_done, 0);
        chk("init_free_count_edge7", free_count, 0);
        cyc();
        chk("init_done_edge8", init_done, 1);
        chk("init_free_count", free_count, 8);
        chk("init_full", full, 1);
        chk("init_low_wm", low_wm, 0);
        chk("init_alloc_valid", alloc_valid, 1);

        // drain: 0..7 back to back
        alloc_req = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain_valid%0d", i), alloc_valid, 1);
            chk($sformatf("drain_ptr%0d", i), alloc_ptr, i);
            cyc();
        end
        chk("drain_empty", empty, 1);
        chk("drain_alloc_valid", alloc_valid, 0);
        chk("drain_low_wm", low_wm, 1);
        chk("drain_free_count", free_count, 0);

        // release 5,2,7 with alloc_req held: no bypass while empty
        release_en = 1'b1; release_ptr = 3'd5;
        chk("nobypass_valid", alloc_valid, 0);
        cyc();
        chk("rel1_free_count", free_count, 1);
        alloc_req = 1'b0;
        release_ptr = 3'd2; cyc();
        release_ptr = 3'd7; cyc();
        release_en = 1'b0;
        chk("rel3_free_count", free_count, 3);
        chk("rel3_low_wm", low_wm, 1);
        alloc_req = 1'b1;
        chk("realloc_ptr0", alloc_ptr, 5); cyc();
        chk("realloc_ptr1", alloc_ptr, 2); cyc();
        chk("realloc_ptr2", alloc_ptr, 7); cyc();
        alloc_req = 1'b0;
        chk("realloc_free_count", free_count, 0);

        // fill to 4, then 20 cycles of simultaneous alloc+release
        q = {0, 1, 3, 4};
        release_en = 1'b1;
        foreach (q[i]) begin release_ptr = q[i][PW-1:0]; cyc(); end
        chk("sim_pre_count", free_count, 4);
        alloc_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            head = q.pop_front();
            release_ptr = PW'((i * 3 + 1) % DEPTH);
            q.push_back((i * 3 + 1) % DEPTH);
            chk($sformatf("sim_ptr%0d", i), alloc_ptr, head);
            cyc();
            chk($sformatf("sim_count%0d", i), free_count, 4);
        end
        release_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            head = q.pop_front();
            chk($sformatf("sim_tail%0d", i), alloc_ptr, head);
            cyc();
        end
        alloc_req = 1'b0;
        chk("sim_post_count", free_count, 0);

        // refill to full, then release while full
        release_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin release_ptr = PW'(i); cyc(); end
        chk("refill_full", full, 1);
        chk("refill_err", release_err, 0);
        release_ptr = 3'd3; cyc();
        release_en = 1'b0;
        chk("full_rel_err", release_err, 1);
        chk("full_rel_count", free_count, 8);
        err_clr = 1'b1; cyc();
        err_clr = 1'b0;
        chk("err_clr", release_err, 0);
        err_clr = 1'b1; release_en = 1'b1; cyc();
        err_clr = 1'b0; release_en = 1'b0;
        chk("err_wins_over_clr", release_err, 1);
        err_clr = 1'b1; cyc();
        err_clr = 1'b0;
        chk("err_clr2", release_err, 0);

        // double free: alloc 0 and 1, release 0 twice
        alloc_req = 1'b1;
        chk("df_alloc0", alloc_ptr, 0); cyc();
        chk("df_alloc1", alloc_ptr, 1); cyc();
        alloc_req = 1'b0;
        release_en = 1'b1; release_ptr = 3'd0; cyc();
        chk("df_first_count", free_count, 7);
        chk("df_first_err", release_err, 0);
        cyc();
        release_en = 1'b0;
`ifdef FREE_PTR_DFREE_CHK_EN
        chk("df_second_count", free_count, 7);
        chk("df_second_err", release_err, 1);
`else
        chk("df_second_count", free_count, 8);
        chk("df_second_err", release_err, 0);
`endif

        // mid-operation reset, release during INIT is dropped
        rst_n = 1'b0; cyc();
        chk("mid_rst_count", free_count, 0);
        chk("mid_rst_init_done", init_done, 0);
        chk("mid_rst_err", release_err, 0);
        chk("mid_rst_valid", alloc_valid, 0);
        rst_n = 1'b1; release_en = 1'b1; release_ptr = 3'd6; cyc();
        release_en = 1'b0;
        chk("init_rel_err", release_err, 1);
        chk("init_rel_valid", alloc_valid, 0);
        repeat (DEPTH - 1) cyc();
        chk("reinit_done", init_done, 1);
        chk("reinit_count", free_count, 8);
        chk("reinit_err_sticky", release_err, 1);
        chk("reinit_ptr0", alloc_ptr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
